bandai_eeprom_ctrl: RTL and testbench

BANDAI_EEPROM_CTRL -- requirements
Module: bandai_eeprom_ctrl

---
 rtl/bandai_pkg.sv | 29 ++
 rtl/bandai_eeprom_ctrl_if.sv | 14 +
 rtl/bandai_sk_gen.sv | 35 +++
 rtl/bandai_eeprom_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_bandai_eeprom_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bandai_pkg.sv
// Shared constants for the Bandai cartridge EEPROM controller.
// Port map, Microwire opcodes and controller state encoding.
// Pure declarations; no logic, no latency, no backpressure.
package bandai_pkg;

  // Cartridge port addresses
  localparam logic [7:0] PA_DATA_LO = 8'hC4;
  localparam logic [7:0] PA_DATA_HI = 8'hC5;
  localparam logic [7:0] PA_ADDR_LO = 8'hC6;
  localparam logic [7:0] PA_ADDR_HI = 8'hC7;
  localparam logic [7:0] PA_CTRL    = 8'hC8;

  // Microwire opcodes that follow the start bit
  localparam logic [1:0] OPC_READ  = 2'b10;
  localparam logic [1:0] OPC_WRITE = 2'b01;
  localparam logic [1:0] OPC_SHORT = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CSUP,
    ST_CMD,
    ST_RDATA,
    ST_WDATA,
    ST_CSGAP,
    ST_BUSY,
    ST_DONE
  } state_t;

endpackage

// File: rtl/bandai_eeprom_ctrl_if.sv
// CPU-side cartridge port bus for the EEPROM controller.
// PDO is combinational from PA; writes are single-cycle PWR strobes.
// No backpressure: the controller silently drops writes it cannot accept.
interface bandai_eeprom_ctrl_if;
  import bandai_pkg::*;

  logic [7:0] PA;
  logic       PWR;
  logic [7:0] PDI;
  logic [7:0] PDO;

  modport master (output PA, PWR, PDI, input PDO);
  modport slave  (input PA, PWR, PDI, output PDO);
endinterface

// File: rtl/bandai_sk_gen.sv
// Microwire SK phase generator: SK_DIV cycles low, then SK_DIV cycles high.
// rise_tick/fall_tick flag the cycle before SK rises/falls; counter restarts at 0 on enable.
// No backpressure; output is held low and counter cleared while en is low.
module bandai_sk_gen #(
  parameter int SK_DIV = 4
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic en,
  output logic sk_hi,
  output logic rise_tick,
  output logic fall_tick
);
  localparam int CW = $clog2(2 * SK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * SK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(SK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  // Free-running bit-period counter while enabled, parked at zero otherwise
  always_comb begin
    cnt_d = '0;
    if (en) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign sk_hi     = en && (cnt_q >= CNT_HALF);
  assign rise_tick = en && (cnt_q == CNT_HALF - 1'b1);
  assign fall_tick = en && (cnt_q == CNT_LAST);
endmodule

// File: rtl/bandai_eeprom_ctrl.sv
// Bandai cartridge port to 93Cxx Microwire EEPROM bridge (READ, WRITE, short commands).
// Commands run for tens to thousands of CLK cycles; STATUS.READY shows completion.
// Port writes to C4h-C8h are dropped while a command is running.
module bandai_eeprom_ctrl
  import bandai_pkg::*;
#(
  parameter int ADDR_BITS = 6,
  parameter int SK_DIV    = 4,
  parameter int BUSY_TO   = 65535
) (
  input  logic CLK,
  input  logic RSTn,
  bandai_eeprom_ctrl_if.slave bus,
  output logic ECS,
  output logic ESK,
  output logic EDI,
  input  logic EDO
);
  localparam int              CMD_W     = 3 + ADDR_BITS;
  localparam logic [4:0]      CMD_BITS  = 5'(CMD_W);
  localparam logic [31:0]     HALF_LAST = 32'(SK_DIV - 1);
  localparam logic [31:0]     BUSY_LAST = 32'(BUSY_TO - 1);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [15:0]      sh_q, sh_d;
  logic [15:0]      data_q, data_d;
  logic [15:0]      addr_q, addr_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [31:0]      wait_q, wait_d;
  logic             rdone_q, rdone_d;
  logic             tmo_q, tmo_d;
  logic             edo_m_q, edo_m_d;
  logic             edo_s_q, edo_s_d;

  logic       sk_en, sk_hi, sk_rise, sk_fall;
  logic       cmd_ok;
  logic [1:0] opc_new;

  assign sk_en = (state_q == ST_CMD) || (state_q == ST_RDATA) || (state_q == ST_WDATA);

  bandai_sk_gen #(.SK_DIV(SK_DIV)) u_sk_gen (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .en        (sk_en),
    .sk_hi     (sk_hi),
    .rise_tick (sk_rise),
    .fall_tick (sk_fall)
  );

  // Decode the CTRL write: exactly one command bit, mapped to its opcode
  always_comb begin
    cmd_ok  = (bus.PDI[6:4] == 3'b001) || (bus.PDI[6:4] == 3'b010) || (bus.PDI[6:4] == 3'b100);
    opc_new = OPC_SHORT;
    if (bus.PDI[4])      opc_new = OPC_READ;
    else if (bus.PDI[5]) opc_new = OPC_WRITE;
  end

  // Next-state, register-file and Microwire sequencing
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cmd_d     = cmd_q;
    sh_d      = sh_q;
    data_d    = data_q;
    addr_d    = addr_q;
    bit_cnt_d = bit_cnt_q;
    wait_d    = wait_q;
    rdone_d   = rdone_q;
    tmo_d     = tmo_q;
    edo_m_d   = EDO;
    edo_s_d   = edo_m_q;

    // bit_cnt counts SK pulses issued in the current field
    if (sk_rise) bit_cnt_d = bit_cnt_q + 5'd1;

    case (state_q)
      ST_IDLE: begin
        if (bus.PWR) begin
          case (bus.PA)
            PA_DATA_LO: data_d[7:0]  = bus.PDI;
            PA_DATA_HI: data_d[15:8] = bus.PDI;
            PA_ADDR_LO: addr_d[7:0]  = bus.PDI;
            PA_ADDR_HI: addr_d[15:8] = bus.PDI;
            PA_CTRL: begin
              if (cmd_ok) begin
                rdone_d   = 1'b0;
                tmo_d     = 1'b0;
                op_d      = opc_new;
                cmd_d     = {1'b1, opc_new, addr_q[ADDR_BITS-1:0]};
                bit_cnt_d = '0;
                wait_d    = '0;
                state_d   = ST_CSUP;
              end
            end
            default: ;
          endcase
        end
      end
      ST_CSUP: begin
        if (wait_q == HALF_LAST) begin
          wait_d  = '0;
          state_d = ST_CMD;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      ST_CMD: begin
        if (sk_fall) begin
          cmd_d = cmd_q << 1;
          if (bit_cnt_q == CMD_BITS) begin
            bit_cnt_d = '0;
            case (op_q)
              OPC_READ:  state_d = ST_RDATA;
              OPC_WRITE: begin
                sh_d    = data_q;
                state_d = ST_WDATA;
              end
              default:   state_d = ST_CSGAP;
            endcase
          end
        end
      end
      ST_RDATA: begin
        // Sampling at the last SK-high cycle absorbs the synchroniser delay
        if (sk_fall) begin
          sh_d = {sh_q[14:0], edo_s_q};
          if (bit_cnt_q == 5'd16) begin
            data_d    = {sh_q[14:0], edo_s_q};
            rdone_d   = 1'b1;
            bit_cnt_d = '0;
            wait_d    = '0;
            state_d   = ST_DONE;
          end
        end
      end
      ST_WDATA: begin
        if (sk_fall) begin
          sh_d = sh_q << 1;
          if (bit_cnt_q == 5'd16) begin
            bit_cnt_d = '0;
            wait_d    = '0;
            state_d   = ST_CSGAP;
          end
        end
      end
      ST_CSGAP: begin
        if (wait_q == HALF_LAST) begin
          wait_d = '0;
          // Only WRITE and ERAL start an internal program cycle worth polling
          if ((op_q == OPC_WRITE) ||
              ((op_q == OPC_SHORT) && (addr_q[ADDR_BITS-1 -: 2] == 2'b10)))
            state_d = ST_BUSY;
          else
            state_d = ST_DONE;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      ST_BUSY: begin
        if (edo_s_q) begin
          wait_d  = '0;
          state_d = ST_DONE;
        end else if (wait_q == BUSY_LAST) begin
          tmo_d   = 1'b1;
          wait_d  = '0;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      ST_DONE: begin
        if (wait_q == HALF_LAST) begin
          wait_d  = '0;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= ST_IDLE;
      op_q      <= OPC_SHORT;
      cmd_q     <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      bit_cnt_q <= '0;
      wait_q    <= '0;
      rdone_q   <= 1'b0;
      tmo_q     <= 1'b0;
      edo_m_q   <= 1'b0;
      edo_s_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cmd_q     <= cmd_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      bit_cnt_q <= bit_cnt_d;
      wait_q    <= wait_d;
      rdone_q   <= rdone_d;
      tmo_q     <= tmo_d;
      edo_m_q   <= edo_m_d;
      edo_s_q   <= edo_s_d;
    end
  end

  // Microwire pins decoded from registered state so reset clears them immediately
  always_comb begin
    ECS = (state_q == ST_CSUP) || sk_en || (state_q == ST_BUSY);
    ESK = sk_hi;
    EDI = 1'b0;
    if (state_q == ST_CMD)   EDI = cmd_q[CMD_W-1];
    if (state_q == ST_WDATA) EDI = sh_q[15];
  end

  // Port read mux
  always_comb begin
    bus.PDO = 8'h00;
    case (bus.PA)
      PA_DATA_LO: bus.PDO = data_q[7:0];
      PA_DATA_HI: bus.PDO = data_q[15:8];
      PA_ADDR_LO: bus.PDO = addr_q[7:0];
      PA_ADDR_HI: bus.PDO = addr_q[15:8];
      PA_CTRL:    bus.PDO = {5'b0, tmo_q, (state_q == ST_IDLE), rdone_q};
      default:    bus.PDO = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_bandai_eeprom_ctrl.sv
// Directed bench for bandai_eeprom_ctrl with a behavioural 93C46-style EEPROM model.
// Commands are issued over the port bus and completion is polled via STATUS.READY.
// All waits are bounded by cycle budgets.
module tb_bandai_eeprom_ctrl;
  import bandai_pkg::*;

  logic CLK = 1'b0;
  logic RSTn;
  logic ECS, ESK, EDI, EDO;

  always #5 CLK = ~CLK;

  bandai_eeprom_ctrl_if bus();

  bandai_eeprom_ctrl #(.ADDR_BITS(6), .SK_DIV(4), .BUSY_TO(200)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus),
    .ECS  (ECS),
    .ESK  (ESK),
    .EDI  (EDI),
    .EDO  (EDO)
  );

  int checks = 0;
  int failures = 0;

  // EEPROM model state (written only by the model process)
  logic [15:0] mem [0:63];
  logic        mdl_edo, ecs_p, esk_p, rd_mode, busy_arm, in_busy;
  logic        force_busy;
  logic [31:0] rx, cap_rx;
  logic [15:0] rd_word;
  int          mdl_n, cap_n, sk_pulses, ecs_rises, busy_run, busy_len, busy_cnt;

  assign EDO = mdl_edo;

  // EEPROM model: edge-detects ECS/ESK on the falling CLK edge
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[21] = 16'hBEEF;
    mdl_edo = 0; ecs_p = 0; esk_p = 0; rd_mode = 0; busy_arm = 0; in_busy = 0;
    rx = 0; cap_rx = 0; rd_word = 0;
    mdl_n = 0; cap_n = 0; sk_pulses = 0; ecs_rises = 0; busy_run = 0; busy_len = 0; busy_cnt = 0;
    forever begin
      @(negedge CLK);
      if (!ECS && ecs_p) begin
        if (in_busy) begin
          busy_len = busy_run; in_busy = 0; busy_arm = 0;
        end else if (mdl_n == 25 && rx[23:22] == 2'b01) begin
          mem[rx[21:16]] = rx[15:0]; busy_arm = 1; busy_cnt = 100;
        end
        if (mdl_n > 0) begin cap_rx = rx; cap_n = mdl_n; end
        rd_mode = 0;
      end
      if (ECS && !ecs_p) begin
        ecs_rises++; mdl_n = 0; rx = 0; rd_mode = 0;
        if (busy_arm) begin in_busy = 1; busy_run = 0; end
      end
      if (ESK && !esk_p) begin
        sk_pulses++;
        if (ECS) begin
          rx = {rx[30:0], EDI}; mdl_n++;
          if (mdl_n == 9 && rx[7:6] == 2'b10) begin rd_mode = 1; rd_word = mem[rx[5:0]]; end
        end
      end
      if (!ESK && esk_p && rd_mode) begin
        mdl_edo = rd_word[15]; rd_word = {rd_word[14:0], 1'b0};
      end
      if (ECS && in_busy) busy_run++;
      if (busy_arm && busy_cnt > 0) busy_cnt--;
      if (in_busy) mdl_edo = (busy_cnt == 0) && !force_busy;
      else if (!rd_mode) mdl_edo = 1'b0;
      ecs_p = ECS; esk_p = ESK;
    end
  end

  task automatic wr(input logic [7:0] pa, input logic [7:0] d);
    @(posedge CLK); #1;
    bus.PA = pa; bus.PDI = d; bus.PWR = 1'b1;
    @(posedge CLK); #1;
    bus.PWR = 1'b0;
  endtask

  task automatic rd(input logic [7:0] pa, output logic [7:0] d);
    bus.PA = pa; #1; d = bus.PDO;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge CLK); #2;
      bus.PA = PA_CTRL; #1;
      if (bus.PDO[1]) begin ok = 1; break; end
    end
  endtask

  task automatic wait_bits(input int target, input int max_cyc, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge CLK); #2;
      if (mdl_n >= target) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    logic [7:0] d;
    RSTn = 1'b0; bus.PA = 8'h00; bus.PDI = 8'h00; bus.PWR = 1'b0; force_busy = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    checks++; if (ECS !== 1'b0) begin failures++; $display("FAIL reset_ecs: got %b expected 0", ECS); end
    checks++; if (ESK !== 1'b0) begin failures++; $display("FAIL reset_esk: got %b expected 0", ESK); end
    checks++; if (EDI !== 1'b0) begin failures++; $display("FAIL reset_edi: got %b expected 0", EDI); end
    rd(PA_CTRL, d);
    checks++; if (d !== 8'h02) begin failures++; $display("FAIL reset_status: got %02h expected 02", d); end
    RSTn = 1'b1;
    @(posedge CLK); #2;
    rd(PA_DATA_LO, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_data_lo: got %02h expected 00", d); end
    rd(PA_ADDR_HI, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_addr_hi: got %02h expected 00", d); end
  endtask

  task automatic test_read;
    logic [7:0] d; bit ok; int sk0;
    wr(PA_ADDR_LO, 8'h15); wr(PA_ADDR_HI, 8'h00);
    sk0 = sk_pulses;
    wr(PA_CTRL, 8'h10);
    wait_idle(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL read_done: not idle within 2000 cycles"); end
    checks++; if (cap_rx[24:16] !== 9'b110010101 || cap_n != 25) begin
      failures++; $display("FAIL read_cmd_bits: got %b n=%0d expected 110010101 n=25", cap_rx[24:16], cap_n); end
    checks++; if (sk_pulses - sk0 != 25) begin failures++; $display("FAIL read_sk_pulses: got %0d expected 25", sk_pulses - sk0); end
    rd(PA_DATA_LO, d);
    checks++; if (d !== 8'hEF) begin failures++; $display("FAIL read_data_lo: got %02h expected EF", d); end
    rd(PA_DATA_HI, d);
    checks++; if (d !== 8'hBE) begin failures++; $display("FAIL read_data_hi: got %02h expected BE", d); end
    rd(PA_CTRL, d);
    checks++; if (d !== 8'h03) begin failures++; $display("FAIL read_status: got %02h expected 03", d); end
    rd(8'hC9, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL read_unmapped: got %02h expected 00", d); end
    checks++; if (ECS !== 1'b0) begin failures++; $display("FAIL read_ecs_end: got %b expected 0", ECS); end
  endtask

  task automatic test_busy_writes;
    logic [7:0] d; bit ok;
    wr(PA_CTRL, 8'h10);
    wait_bits(12, 1000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL busy_reach_rdata: no data phase within 1000 cycles"); end
    wr(PA_DATA_LO, 8'hAA);
    wr(PA_ADDR_LO, 8'h3F);
    rd(PA_DATA_LO, d);
    checks++; if (d !== 8'hEF) begin failures++; $display("FAIL busy_data_frozen: got %02h expected EF", d); end
    rd(PA_ADDR_LO, d);
    checks++; if (d !== 8'h15) begin failures++; $display("FAIL busy_addr_frozen: got %02h expected 15", d); end
    wait_idle(2000, ok);
    rd(PA_DATA_HI, d);
    checks++; if (d !== 8'hBE) begin failures++; $display("FAIL busy_read_hi: got %02h expected BE", d); end
  endtask

  task automatic test_write;
    logic [7:0] d; bit ok; int sk0, er0;
    wr(PA_DATA_LO, 8'h34); wr(PA_DATA_HI, 8'h12);
    wr(PA_ADDR_LO, 8'h03); wr(PA_ADDR_HI, 8'h00);
    sk0 = sk_pulses; er0 = ecs_rises;
    wr(PA_CTRL, 8'h20);
    wait_idle(3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL write_done: not idle within 3000 cycles"); end
    checks++; if (sk_pulses - sk0 != 25) begin failures++; $display("FAIL write_sk_pulses: got %0d expected 25", sk_pulses - sk0); end
    checks++; if (ecs_rises - er0 != 2) begin failures++; $display("FAIL write_cs_count: got %0d expected 2", ecs_rises - er0); end
    rd(PA_CTRL, d);
    checks++; if (d !== 8'h02) begin failures++; $display("FAIL write_status: got %02h expected 02", d); end
    checks++; if (mem[3] !== 16'h1234) begin failures++; $display("FAIL write_mem: got %04h expected 1234", mem[3]); end
  endtask

  task automatic test_timeout;
    logic [7:0] d; bit ok;
    force_busy = 1'b1;
    wr(PA_DATA_LO, 8'h5A); wr(PA_DATA_HI, 8'h5A); wr(PA_ADDR_LO, 8'h04);
    wr(PA_CTRL, 8'h20);
    wait_idle(3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL timeout_done: not idle within 3000 cycles"); end
    checks++; if (busy_len != 200) begin failures++; $display("FAIL timeout_busy_len: got %0d expected 200", busy_len); end
    rd(PA_CTRL, d);
    checks++; if (d !== 8'h06) begin failures++; $display("FAIL timeout_status: got %02h expected 06", d); end
    checks++; if (ECS !== 1'b0) begin failures++; $display("FAIL timeout_ecs: got %b expected 0", ECS); end
    force_busy = 1'b0;
  endtask

  task automatic test_illegal;
    logic [7:0] d; int er0;
    er0 = ecs_rises;
    wr(PA_CTRL, 8'h30); wr(PA_CTRL, 8'h00); wr(PA_CTRL, 8'h70);
    repeat (30) @(posedge CLK);
    #2;
    checks++; if (ecs_rises != er0) begin failures++; $display("FAIL illegal_cs: got %0d cs pulses expected 0", ecs_rises - er0); end
    rd(PA_CTRL, d);
    checks++; if (d !== 8'h06) begin failures++; $display("FAIL illegal_status: got %02h expected 06", d); end
  endtask

  task automatic test_ewen;
    logic [7:0] d; bit ok; int sk0, er0;
    wr(PA_ADDR_LO, 8'h30); wr(PA_ADDR_HI, 8'h00);
    sk0 = sk_pulses; er0 = ecs_rises;
    wr(PA_CTRL, 8'h40);
    wait_idle(1000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ewen_done: not idle within 1000 cycles"); end
    checks++; if (sk_pulses - sk0 != 9) begin failures++; $display("FAIL ewen_sk_pulses: got %0d expected 9", sk_pulses - sk0); end
    checks++; if (ecs_rises - er0 != 1) begin failures++; $display("FAIL ewen_no_busy: got %0d cs pulses expected 1", ecs_rises - er0); end
    checks++; if (cap_rx[8:0] !== 9'b100110000 || cap_n != 9) begin
      failures++; $display("FAIL ewen_cmd_bits: got %b n=%0d expected 100110000 n=9", cap_rx[8:0], cap_n); end
    rd(PA_CTRL, d);
    checks++; if (d !== 8'h02) begin failures++; $display("FAIL ewen_status: got %02h expected 02", d); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d; bit ok, hi;
    wr(PA_CTRL, 8'h20);
    wait_bits(12, 1000, ok);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (ESK) begin hi = 1; break; end
      @(posedge CLK); #2;
    end
    checks++; if (!ok || !hi) begin failures++; $display("FAIL rstmid_reach_wdata: got ok=%b sk=%b expected 1 1", ok, hi); end
    RSTn = 1'b0; #1;
    checks++; if ({ECS, ESK, EDI} !== 3'b000) begin failures++; $display("FAIL rstmid_pins: got %b expected 000", {ECS, ESK, EDI}); end
    rd(PA_CTRL, d);
    checks++; if (d !== 8'h02) begin failures++; $display("FAIL rstmid_status: got %02h expected 02", d); end
    rd(PA_DATA_LO, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rstmid_data: got %02h expected 00", d); end
    rd(PA_ADDR_LO, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL rstmid_addr: got %02h expected 00", d); end
    @(posedge CLK); #2;
    RSTn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_read();
    test_busy_writes();
    test_write();
    test_timeout();
    test_illegal();
    test_ewen();
    test_reset_mid();
    repeat (5) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
